// File: rtl/dpll_pkg.sv
// ---------------------------------------------------------------------------
// dpll_pkg
// Shared definitions for the all-digital PLL increment/decrement stage.
//   ID_W_DEF    : default phase counter width (idout period = 2**ID_W clocks)
//   N_DIV_DEF   : default feedback divide ratio (idout periods per fout period)
//   PEND_W_DEF  : default width of the signed pending-correction register
//   PEND_MAX/MIN: symmetric saturation limits of the pending register
//   pend_t      : signed pending-correction type at the default width
//   corr_e      : kind of phase correction applied in a given clock cycle
// ---------------------------------------------------------------------------
package dpll_pkg;

    localparam int ID_W_DEF   = 2;
    localparam int N_DIV_DEF  = 16;
    localparam int PEND_W_DEF = 4;

    // The range is kept symmetric: the most negative two's complement code
    // is never used, so a saturated advance and retard have equal weight.
    localparam int PEND_MAX = (2 ** (PEND_W_DEF - 1)) - 1;
    localparam int PEND_MIN = -PEND_MAX;

    typedef logic signed [PEND_W_DEF-1:0] pend_t;

    typedef enum logic [1:0] {
        CORR_NONE = 2'd0,   // nominal step of one phase count
        CORR_ADV  = 2'd1,   // skip one count: period shortened by one clock
        CORR_RET  = 2'd2    // hold one count: period lengthened by one clock
    } corr_e;

    // Saturation limit for a pending register of arbitrary width.
    function automatic int pend_max_of(input int w);
        return (2 ** (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/dpll_div_n.sv
// ---------------------------------------------------------------------------
// dpll_div_n
// Divides the recovered clock by N_DIV to produce the feedback clock fout.
// The divider counts idout rising-edge strobes rather than sampling idout,
// so it works in the Kclock domain without any extra edge detector.
//   Kclock : system clock
//   reset  : asynchronous, active-low reset
//   rise   : one-cycle strobe, high in the cycle before idout goes 0->1
//   fout   : registered output, toggles every N_DIV/2 strobes
// ---------------------------------------------------------------------------
module dpll_div_n
    import dpll_pkg::*;
#(
    parameter int N_DIV = N_DIV_DEF
) (
    input  logic Kclock,
    input  logic reset,
    input  logic rise,
    output logic fout
);

    localparam int HALF  = N_DIV / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CNT_W-1:0] cnt;
    logic             fout_q;

    always_ff @(posedge Kclock or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            fout_q <= 1'b0;
        end else if (rise) begin
            // Half of the fout period has elapsed after HALF idout rises.
            if (cnt == CNT_W'(HALF - 1)) begin
                cnt    <= '0;
                fout_q <= ~fout_q;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign fout = fout_q;

endmodule

// File: rtl/dpll_id_counter.sv
// ---------------------------------------------------------------------------
// dpll_id_counter
// Increment/decrement stage of the all-digital PLL, fed by the K counter.
// Carry pulses advance the recovered clock idout by one Kclock period and
// borrow pulses retard it by one; requests accumulate in a signed pending
// register and are applied at most once per idout period. idout is further
// divided by N_DIV to form fout, the feedback to the phase detector.
//   Kclock  : system clock, shared with the K counter
//   reset   : asynchronous, active-low reset
//   enable  : loop enable; low ignores carry/borrow and clears pending
//   carry   : one-cycle advance request
//   borrow  : one-cycle retard request
//   idout   : recovered clock, MSB of the phase counter
//   fout    : idout divided by N_DIV
//   pending : signed net corrections not yet applied
//   ovf     : sticky flag, pending has saturated at least once
// ---------------------------------------------------------------------------
module dpll_id_counter
    import dpll_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int N_DIV  = N_DIV_DEF,
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic                     Kclock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     carry,
    input  logic                     borrow,
    output logic                     idout,
    output logic                     fout,
    output logic signed [PEND_W-1:0] pending,
    output logic                     ovf
);

    localparam int PMAX  = pend_max_of(PEND_W);
    // Two guard bits hold pend plus a request and an applied correction
    // (at most +/-2 beyond the limit) without wrapping.
    localparam int SUM_W = PEND_W + 2;

    typedef logic signed [SUM_W-1:0] sum_t;

    logic [ID_W-1:0]          ph;
    logic [ID_W-1:0]          ph_next;
    logic signed [PEND_W-1:0] pend;
    logic signed [PEND_W-1:0] pend_next;
    logic                     corr_done;
    logic                     corr_done_next;
    logic                     ovf_q;
    logic                     ovf_next;
    logic                     idout_rise;
    logic                     idout_fall;
    corr_e                    corr;
    sum_t                     d_req;
    sum_t                     d_app;
    sum_t                     pend_sum;

    function automatic logic signed [PEND_W-1:0] sat_pend(input sum_t s);
        if (s > sum_t'(PMAX)) begin
            return PEND_W'(PMAX);
        end else if (s < sum_t'(-PMAX)) begin
            return PEND_W'(-PMAX);
        end else begin
            return s[PEND_W-1:0];
        end
    endfunction

    function automatic logic is_sat(input sum_t s);
        return (s > sum_t'(PMAX)) || (s < sum_t'(-PMAX));
    endfunction

    always_comb begin
        corr           = CORR_NONE;
        ph_next        = ph + ID_W'(1);
        corr_done_next = corr_done;
        d_req          = '0;
        d_app          = '0;
        pend_sum       = '0;
        pend_next      = pend;
        ovf_next       = ovf_q;

        // One correction per idout period: corr_done blocks a second one
        // until idout has fallen again.
        if (enable && !corr_done && (pend != '0)) begin
            corr = pend[PEND_W-1] ? CORR_RET : CORR_ADV;
        end

        case (corr)
            CORR_ADV: ph_next = ph + ID_W'(2);
            CORR_RET: ph_next = ph;
            default:  ph_next = ph + ID_W'(1);
        endcase

        idout_rise = ~ph[ID_W-1] &  ph_next[ID_W-1];
        idout_fall =  ph[ID_W-1] & ~ph_next[ID_W-1];

        // An advance can wrap the counter and cause a fall in the same cycle
        // it is applied; setting must win or a second advance would follow.
        if (corr != CORR_NONE) begin
            corr_done_next = 1'b1;
        end else if (idout_fall) begin
            corr_done_next = 1'b0;
        end

        // Simultaneous carry and borrow cancel.
        if (carry && !borrow) begin
            d_req = sum_t'(1);
        end else if (borrow && !carry) begin
            d_req = sum_t'(-1);
        end

        if (corr == CORR_ADV) begin
            d_app = sum_t'(-1);
        end else if (corr == CORR_RET) begin
            d_app = sum_t'(1);
        end

        pend_sum = sum_t'(pend) + d_req + d_app;

        if (!enable) begin
            pend_next = '0;
        end else begin
            pend_next = sat_pend(pend_sum);
            ovf_next  = ovf_q | is_sat(pend_sum);
        end
    end

    always_ff @(posedge Kclock or negedge reset) begin
        if (!reset) begin
            ph        <= '0;
            pend      <= '0;
            corr_done <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            ph        <= ph_next;
            pend      <= pend_next;
            corr_done <= corr_done_next;
            ovf_q     <= ovf_next;
        end
    end

    dpll_div_n #(
        .N_DIV (N_DIV)
    ) u_div (
        .Kclock (Kclock),
        .reset  (reset),
        .rise   (idout_rise),
        .fout   (fout)
    );

    assign idout   = ph[ID_W-1];
    assign pending = pend;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_dpll_id_counter.sv
module tb_dpll_id_counter;
    import dpll_pkg::*;

    localparam int ID_W   = 2;
    localparam int N_DIV  = 16;
    localparam int PEND_W = 4;
    localparam int PER    = 1 << ID_W;
    localparam int PMAX   = PEND_MAX;

    logic Kclock = 1'b0;
    logic reset  = 1'b0;
    logic enable = 1'b0;
    logic carry  = 1'b0;
    logic borrow = 1'b0;
    logic idout;
    logic fout;
    logic signed [PEND_W-1:0] pending;
    logic ovf;

    dpll_id_counter #(
        .ID_W   (ID_W),
        .N_DIV  (N_DIV),
        .PEND_W (PEND_W)
    ) dut (
        .Kclock  (Kclock),
        .reset   (reset),
        .enable  (enable),
        .carry   (carry),
        .borrow  (borrow),
        .idout   (idout),
        .fout    (fout),
        .pending (pending),
        .ovf     (ovf)
    );

    always #5 Kclock = ~Kclock;

    int checks   = 0;
    int failures = 0;
    int ncyc     = 0;
    bit cmp_en   = 0;

    // reference model state: phase as an integer, pending as an integer
    int m_ph, m_pend, m_rises;
    bit m_done, m_ovf, m_fout;

    int rq[$];   // cycle numbers of idout rising edges
    int fq[$];   // cycle numbers of fout rising edges

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", nm, act, exp, ncyc);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timeout cycle=%0d", nm, ncyc);
    endtask

    task automatic model_reset();
        m_ph = 0; m_pend = 0; m_rises = 0;
        m_done = 0; m_ovf = 0; m_fout = 0;
    endtask

    task automatic model_step();
        int adj, np, v;
        bit om, nm;
        if (!reset) begin
            model_reset();
            return;
        end
        adj = 0;
        if (enable && !m_done && m_pend != 0) adj = (m_pend > 0) ? 1 : -1;
        np = (m_ph + 1 + adj) % PER;
        om = (m_ph >= PER / 2);
        nm = (np >= PER / 2);
        if (adj != 0) m_done = 1;
        else if (om && !nm) m_done = 0;
        if (!enable) begin
            m_pend = 0;
        end else begin
            v = m_pend + int'(carry) - int'(borrow) - adj;
            if (v > PMAX) begin v = PMAX; m_ovf = 1; end
            else if (v < -PMAX) begin v = -PMAX; m_ovf = 1; end
            m_pend = v;
        end
        if (!om && nm) begin
            m_rises++;
            if (m_rises == N_DIV / 2) begin
                m_rises = 0;
                m_fout = ~m_fout;
            end
        end
        m_ph = np;
    endtask

    // one clock: model steps on the same edge as the DUT; inputs change #1 later
    task automatic cyc();
        logic pi, pf;
        pi = idout;
        pf = fout;
        @(posedge Kclock);
        model_step();
        ncyc++;
        #1;
        if (!pi && idout) rq.push_back(ncyc);
        if (!pf && fout) fq.push_back(ncyc);
    endtask

    task automatic next_rise(output int t);
        int n;
        n = rq.size();
        t = -1;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (rq.size() > n) begin
                t = rq[$];
                break;
            end
        end
        if (t < 0) timeout("idout_rise");
    endtask

    task automatic next_frise(output int t);
        int n;
        n = fq.size();
        t = -1;
        for (int k = 0; k < 200; k++) begin
            cyc();
            if (fq.size() > n) begin
                t = fq[$];
                break;
            end
        end
        if (t < 0) timeout("fout_rise");
    endtask

    // every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge Kclock);
            if (cmp_en) begin
                chk("model_idout", int'(idout), int'(m_ph >= PER / 2));
                chk("model_fout", int'(fout), int'(m_fout));
                chk("model_pending", int'(pending), m_pend);
                chk("model_ovf", int'(ovf), int'(m_ovf));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired cycle=%0d", ncyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, r1, r2, r3, f0, f1, mode;
        bit found;
        model_reset();

        // reset state
        cyc(); cyc();
        chk("rst_idout", int'(idout), 0);
        chk("rst_fout", int'(fout), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_ovf", int'(ovf), 0);
        reset = 1'b1;
        enable = 1'b1;
        cmp_en = 1;

        // 1: nominal periods, duty, fout period
        next_rise(r0); next_rise(r1); next_rise(r2);
        chk("t1_period_a", r1 - r0, 4);
        chk("t1_period_b", r2 - r1, 4);
        chk("t1_high0", int'(idout), 1);
        cyc(); chk("t1_high1", int'(idout), 1);
        cyc(); chk("t1_low0", int'(idout), 0);
        next_frise(f0); next_frise(f1);
        chk("t1_fout_period", f1 - f0, 64);
        chk("t1_pending", int'(pending), 0);
        chk("t1_ovf", int'(ovf), 0);

        // 2: single carry
        next_rise(r0);
        carry = 1'b1; cyc(); carry = 1'b0;
        chk("t2_pending_p1", int'(pending), 1);
        cyc();
        chk("t2_pending_0", int'(pending), 0);
        next_rise(r1); next_rise(r2); next_rise(r3);
        chk("t2_short", r1 - r0, 3);
        chk("t2_after_a", r2 - r1, 4);
        chk("t2_after_b", r3 - r2, 4);

        // 3: single borrow
        next_rise(r0);
        borrow = 1'b1; cyc(); borrow = 1'b0;
        chk("t3_pending_m1", int'(pending), -1);
        cyc();
        chk("t3_pending_0", int'(pending), 0);
        next_rise(r1); next_rise(r2); next_rise(r3);
        chk("t3_long", r1 - r0, 5);
        chk("t3_after_a", r2 - r1, 4);
        chk("t3_after_b", r3 - r2, 4);

        // 4: three consecutive carries
        rq.delete();
        next_rise(r0);
        carry = 1'b1; cyc(); cyc(); cyc(); carry = 1'b0;
        next_rise(r1); next_rise(r1); next_rise(r1);
        if (rq.size() == 5) begin
            chk("t4_p1", rq[1] - rq[0], 3);
            chk("t4_p2", rq[2] - rq[1], 3);
            chk("t4_p3", rq[3] - rq[2], 3);
            chk("t4_p4", rq[4] - rq[3], 4);
        end else begin
            chk("t4_rise_count", rq.size(), 5);
        end
        chk("t4_pending", int'(pending), 0);

        // 5: carry and borrow together
        next_rise(r0);
        carry = 1'b1; borrow = 1'b1; cyc(); carry = 1'b0; borrow = 1'b0;
        chk("t5_pending", int'(pending), 0);
        next_rise(r1); next_rise(r2);
        chk("t5_period_a", r1 - r0, 4);
        chk("t5_period_b", r2 - r1, 4);

        // 6: saturation, disable, async reset mid-period
        next_rise(r0);
        carry = 1'b1;
        repeat (20) cyc();
        chk("t6_sat", int'(pending), 7);
        chk("t6_ovf", int'(ovf), 1);
        enable = 1'b0;
        cyc();
        chk("t6_dis_pending", int'(pending), 0);
        chk("t6_dis_ovf", int'(ovf), 1);
        cyc();
        chk("t6_dis_pending2", int'(pending), 0);
        carry = 1'b0;
        found = 0;
        for (int k = 0; k < 300; k++) begin
            cyc();
            if (idout && fout) begin found = 1; break; end
        end
        if (!found) timeout("t6_wait_high");
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_idout", int'(idout), 0);
        chk("t6_rst_fout", int'(fout), 0);
        chk("t6_rst_ovf", int'(ovf), 0);
        chk("t6_rst_pending", int'(pending), 0);
        cyc(); cyc();
        reset = 1'b1;
        enable = 1'b1;

        // randomized traffic: sparse pulses, carry bursts, borrow bursts
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) mode = $urandom_range(0, 2);
            enable = ($urandom_range(0, 29) != 0);
            case (mode)
                1: begin
                    carry  = ($urandom_range(0, 3) != 0);
                    borrow = ($urandom_range(0, 7) == 0);
                end
                2: begin
                    carry  = ($urandom_range(0, 7) == 0);
                    borrow = ($urandom_range(0, 3) != 0);
                end
                default: begin
                    carry  = ($urandom_range(0, 5) == 0);
                    borrow = ($urandom_range(0, 5) == 0);
                end
            endcase
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                model_reset();
                cyc(); cyc();
                reset = 1'b1;
            end
            cyc();
        end
        carry = 1'b0;
        borrow = 1'b0;
        cyc(); cyc();

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
